// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI packet slave: FSM states, byte width,
// default start byte and the checksum XOR reduction.
package spi_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_BYTES = 16;
  localparam int MAX_W = MAX_BYTES * BYTE_W;
  localparam logic [BYTE_W-1:0] START_BYTE_DEF = 8'h11;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    ACCEPT  = 2'd2
  } pkt_state_e;

  // XOR of the low n bytes; byte order is irrelevant for XOR.
  function automatic logic [BYTE_W-1:0] xor_bytes(input logic [MAX_W-1:0] d, input int n);
    logic [BYTE_W-1:0] x;
    x = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i < n) x ^= d[i*BYTE_W +: BYTE_W];
    return x;
  endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte engine oversampled by i_clk: synchronisers, edge detect,
// bit counter, RX/TX shifters, completed-byte strobe and MISO drive.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sclk,
  input  logic              i_ssel,
  input  logic              i_mosi,
  input  logic [BYTE_W-1:0] i_tx_byte,
  output logic              o_miso,
  output logic              o_byte_valid,
  output logic [BYTE_W-1:0] o_byte
);

  logic [SYNC_STAGES-1:0] sclk_sync, ssel_sync, mosi_sync;
  logic sclk_d, ssel_d;
  logic sclk_s, ssel_s, mosi_s;
  logic sclk_rise, sclk_fall, ssel_fall;

  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] rx_sh;
  logic [BYTE_W-2:0] tx_sh;
  logic [BYTE_W-1:0] rx_next;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ssel_s = ssel_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ssel_fall = ~ssel_s & ssel_d;
  assign rx_next   = {rx_sh, mosi_s};

  // SSEL chain resets to the idle (high) level so reset release is not a frame start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= '0;
      ssel_sync <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ssel_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], i_ssel};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_s;
      ssel_d    <= ssel_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt      <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      o_miso       <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (ssel_s) begin
        bit_cnt <= '0;
        o_miso  <= 1'b0;
      end else if (ssel_fall) begin
        bit_cnt <= '0;
        tx_sh   <= i_tx_byte[BYTE_W-2:0];
        o_miso  <= i_tx_byte[BYTE_W-1];
      end else if (sclk_rise) begin
        rx_sh   <= rx_next[BYTE_W-2:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_byte       <= rx_next;
          o_byte_valid <= 1'b1;
        end
      end else if (sclk_fall) begin
        // Zeros shift in behind the last bit, so MISO idles low after bit 0.
        o_miso <= tx_sh[BYTE_W-2];
        tx_sh  <= {tx_sh[BYTE_W-3:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_packet_slave.sv
// SPI packet slave: hunts for START_BYTE, collects PKT_BYTES payload bytes,
// publishes the packet. Optional checksum byte enabled by SPI_PKT_CHECKSUM_EN.
module spi_packet_slave
  import spi_pkg::*;
#(
  parameter int              PKT_BYTES      = 5,
  parameter logic [7:0]      START_BYTE     = START_BYTE_DEF,
  parameter int              SYNC_STAGES    = 2,
  parameter int              TIMEOUT_CYCLES = 0,
  localparam int             PW             = 8 * PKT_BYTES
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_SCLK,
  input  logic          i_SSEL,
  input  logic          i_MOSI,
  input  logic [7:0]    i_tx_byte,
  output logic          o_MISO,
  output logic          o_LED,
  output logic          o_byte_valid,
  output logic [7:0]    o_byte,
  output logic          o_packet_received,
  output logic [PW-1:0] o_packet_data_received,
  output logic          o_timeout
`ifdef SPI_PKT_CHECKSUM_EN
  ,
  output logic          o_packet_error
`endif
);

  localparam int  IDX_W  = $clog2(PKT_BYTES + 2);
  localparam bit  TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int  TMO_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic       eng_valid;
  logic [7:0] eng_byte;

  spi_byte_engine #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_eng (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sclk      (i_SCLK),
    .i_ssel      (i_SSEL),
    .i_mosi      (i_MOSI),
    .i_tx_byte   (i_tx_byte),
    .o_miso      (o_MISO),
    .o_byte_valid(eng_valid),
    .o_byte      (eng_byte)
  );

  assign o_byte_valid = eng_valid;
  assign o_byte       = eng_byte;

  pkt_state_e       state, state_nxt;
  logic [PW-1:0]    staging;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             shift_en, tmo_fire, cs_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= HUNT;
    else       state <= state_nxt;
  end

  // A completed byte always takes precedence over an expiring timeout.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    tmo_fire  = 1'b0;
    cs_err    = 1'b0;
    case (state)
      HUNT: if (eng_valid && eng_byte == START_BYTE) state_nxt = COLLECT;
      COLLECT: begin
        if (eng_valid) begin
`ifdef SPI_PKT_CHECKSUM_EN
          if (idx == IDX_W'(PKT_BYTES)) begin
            if (eng_byte == xor_bytes(MAX_W'(staging), PKT_BYTES)) begin
              state_nxt = ACCEPT;
            end else begin
              cs_err    = 1'b1;
              state_nxt = HUNT;
            end
          end else begin
            shift_en = 1'b1;
          end
`else
          shift_en = 1'b1;
          if (idx == IDX_W'(PKT_BYTES - 1)) state_nxt = ACCEPT;
`endif
        end else if (TMO_EN && tmo_cnt == TMO_MAX) begin
          tmo_fire  = 1'b1;
          state_nxt = HUNT;
        end
      end
      ACCEPT:  state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      staging                <= '0;
      idx                    <= '0;
      tmo_cnt                <= '0;
      o_packet_data_received <= '0;
      o_packet_received      <= 1'b0;
      o_LED                  <= 1'b0;
      o_timeout              <= 1'b0;
    end else begin
      o_packet_received <= 1'b0;
      o_timeout         <= tmo_fire;

      if (state == HUNT) begin
        staging <= '0;
        idx     <= '0;
      end else if (shift_en) begin
        staging <= PW'({staging, eng_byte});
        idx     <= idx + IDX_W'(1);
      end

      if (eng_valid || tmo_fire || state != COLLECT) tmo_cnt <= '0;
      else if (TMO_EN)                               tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state == ACCEPT) begin
        o_packet_data_received <= staging;
        o_packet_received      <= 1'b1;
        o_LED                  <= ~o_LED;
      end
    end
  end

`ifdef SPI_PKT_CHECKSUM_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_packet_error <= 1'b0;
    else       o_packet_error <= cs_err;
  end
`else
  logic unused_cs;
  assign unused_cs = cs_err;
`endif

endmodule

// File: tb/tb_spi_packet_slave.sv
// Self-checking bench for spi_packet_slave: directed scenarios plus random
// byte streams compared against a queue-based packet model.
module tb_spi_packet_slave;

  localparam int TMO = 200;
`ifdef SPI_PKT_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        sclk = 1'b0, ssel = 1'b1, mosi = 1'b0;
  logic [7:0]  tx_byte = 8'h00;
  logic        miso, led, bv, pkt, tmo;
  logic [7:0]  rx_byte;
  logic [39:0] pdata;
`ifdef SPI_PKT_CHECKSUM_EN
  logic        perr;
`endif

  spi_packet_slave #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_SCLK(sclk), .i_SSEL(ssel), .i_MOSI(mosi),
    .i_tx_byte(tx_byte), .o_MISO(miso), .o_LED(led), .o_byte_valid(bv),
    .o_byte(rx_byte), .o_packet_received(pkt), .o_packet_data_received(pdata),
    .o_timeout(tmo)
`ifdef SPI_PKT_CHECKSUM_EN
    , .o_packet_error(perr)
`endif
  );

  always #5 clk = ~clk;

  int n_bv = 0, n_pkt = 0, n_tmo = 0, n_err = 0;
  always @(posedge clk) begin
    if (bv)  n_bv  <= n_bv + 1;
    if (pkt) n_pkt <= n_pkt + 1;
    if (tmo) n_tmo <= n_tmo + 1;
`ifdef SPI_PKT_CHECKSUM_EN
    if (perr) n_err <= n_err + 1;
`endif
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: packet-level view of the byte stream.
  bit          hunting = 1'b1;
  logic [7:0]  q[$];
  logic [39:0] exp_data = '0;
  bit          exp_led = 1'b0;
  int          exp_pkts = 0, exp_tmo = 0, exp_cserr = 0;

  task automatic model_byte(input logic [7:0] b);
    logic [39:0] d;
    logic [7:0]  x;
    bit          ok;
    if (hunting) begin
      if (b == 8'h11) begin hunting = 1'b0; q.delete(); end
    end else begin
      q.push_back(b);
      if (q.size() == NB) begin
        d = '0; x = '0;
        for (int i = 0; i < 5; i++) begin d = {d[31:0], q[i]}; x ^= q[i]; end
        ok = (NB == 5) ? 1'b1 : (q[5] == x);
        if (ok) begin exp_data = d; exp_led = ~exp_led; exp_pkts++; end
        else exp_cserr++;
        hunting = 1'b1;
      end
    end
  endtask

  task automatic model_gap(input int cycles);
    if (cycles > TMO && !hunting) begin hunting = 1'b1; exp_tmo++; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] tx);
    logic [7:0] mb;
    tx_byte = tx;
    @(negedge clk); ssel = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      mb[i] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    chk("o_byte", 64'(rx_byte), 64'(b));
    chk("miso_bits", 64'(mb), 64'(tx));
    model_byte(b);
  endtask

  task automatic partial_frame(input int nbits);
    @(negedge clk); ssel = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk); sclk = 1'b1;
      repeat (4) @(negedge clk); sclk = 1'b0;
    end
    repeat (4) @(negedge clk); ssel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pkts"}, 64'(n_pkt), 64'(exp_pkts));
    chk({tag, "_data"}, 64'(pdata), 64'(exp_data));
    chk({tag, "_led"},  64'(led),   64'(exp_led));
    chk({tag, "_tmo"},  64'(n_tmo), 64'(exp_tmo));
    chk({tag, "_cserr"}, 64'(n_err), 64'(exp_cserr));
  endtask

  initial begin
    int bv0;
    logic [7:0] seq1[10];
    seq1 = '{8'hFF, 8'h12, 8'h5A, 8'h11, 8'h12, 8'hF1, 8'h00, 8'hF4, 8'hF3, 8'hFF};

    repeat (4) @(negedge clk);
    chk("reset_outputs", 64'({miso, led, bv, rx_byte, pkt, pdata, tmo}), 64'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Start byte hunt with leading noise.
    bv0 = n_bv;
    foreach (seq1[i]) send_byte(seq1[i], 8'($urandom));
    chk("t1_strobes", 64'(n_bv - bv0), 64'(10));
    check_state("t1");
`ifndef SPI_PKT_CHECKSUM_EN
    chk("t1_literal", 64'(pdata), 64'(40'h12F100F4F3));
    chk("t1_led", 64'(led), 64'(1));
`endif

    // Embedded start byte is payload.
    send_byte(8'h11, 8'h00);
    send_byte(8'h11, 8'h00); send_byte(8'h22, 8'h00); send_byte(8'h33, 8'h00);
    send_byte(8'h44, 8'h00); send_byte(8'h55, 8'h00);
    check_state("t2");
`ifndef SPI_PKT_CHECKSUM_EN
    chk("t2_literal", 64'(pdata), 64'(40'h1122334455));
`endif

    // Partial byte dropped, packet state kept.
    bv0 = n_bv;
    send_byte(8'h11, 8'h3C); send_byte(8'h12, 8'hC3);
    partial_frame(4);
    send_byte(8'hF1, 8'h00); send_byte(8'h00, 8'hFF);
    send_byte(8'hF4, 8'h81); send_byte(8'hF3, 8'h7E);
    chk("t3_strobes", 64'(n_bv - bv0), 64'(6));
    check_state("t3");

    // Inter-byte timeout aborts the packet.
    send_byte(8'h11, 8'h00); send_byte(8'h12, 8'h00);
    repeat (300) @(negedge clk);
    model_gap(300);
    chk("t4_timeout", 64'(n_tmo), 64'(exp_tmo));
    send_byte(8'hF1, 8'h00); send_byte(8'h00, 8'h00);
    send_byte(8'hF4, 8'h00); send_byte(8'hF3, 8'h00);
    check_state("t4");

    // MISO pattern, then reset mid-byte.
    send_byte(8'h5A, 8'hA5);
    chk("t5_miso_idle", 64'(miso), 64'(0));
    send_byte(8'h11, 8'h00);
    @(negedge clk); ssel = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk); sclk = 1'b1;
      repeat (4) @(negedge clk); sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_reset_outputs", 64'({miso, led, bv, rx_byte, pkt, pdata, tmo}), 64'(0));
    ssel = 1'b1; sclk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hunting = 1'b1; q.delete(); exp_data = '0; exp_led = 1'b0;
    repeat (4) @(negedge clk);
    // Back in HUNT: payload without a start byte is ignored.
    send_byte(8'h12, 8'h00); send_byte(8'hF1, 8'h00); send_byte(8'h00, 8'h00);
    send_byte(8'hF4, 8'h00); send_byte(8'hF3, 8'h00);
    check_state("t5");

`ifdef SPI_PKT_CHECKSUM_EN
    send_byte(8'h11, 8'h00); send_byte(8'h12, 8'h00); send_byte(8'hF1, 8'h00);
    send_byte(8'h00, 8'h00); send_byte(8'hF4, 8'h00); send_byte(8'hF3, 8'h00);
    send_byte(8'hE4, 8'h00);
    check_state("cs_good");
    chk("cs_good_literal", 64'(pdata), 64'(40'h12F100F4F3));
    send_byte(8'h11, 8'h00); send_byte(8'h12, 8'h00); send_byte(8'hF1, 8'h00);
    send_byte(8'h00, 8'h00); send_byte(8'hF4, 8'h00); send_byte(8'hF3, 8'h00);
    send_byte(8'hE5, 8'h00);
    check_state("cs_bad");
`endif

    // Random byte streams with occasional long gaps.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'h11 : 8'($urandom);
      send_byte(b, 8'($urandom));
      if ($urandom_range(0, 11) == 0) begin
        repeat (300) @(negedge clk);
        model_gap(300);
      end
    end
    check_state("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_packet_slave.md
Name: spi_packet_slave

Overview:
Parametrised successor to the fixed 5-byte SPI slave. Mode-0 SPI slave oversampled by the system clock. Hunts for a configurable start byte, then assembles PKT_BYTES payload bytes into one packet word. Adds MISO transmit of a host-supplied byte, per-byte strobes, an inter-byte timeout, and an optional checksum. Sits between the external SPI master pins and the clock-control register logic.

Parameters:
PKT_BYTES, 5, payload bytes per packet (1..16); packet width PW = 8*PKT_BYTES
START_BYTE, 8'h11, byte value that opens a packet while hunting
SYNC_STAGES, 2, synchroniser flops on i_SCLK/i_SSEL/i_MOSI (>=2)
TIMEOUT_CYCLES, 0, i_clk cycles allowed between payload bytes; 0 disables timeout

Ports:
i_clk  in  1  system clock; the only clock
i_rst  in  1  reset, asynchronous, active-high
i_SCLK  in  1  SPI clock (async); must be <= i_clk/4
i_SSEL  in  1  slave select, active low (async)
i_MOSI  in  1  master-out data (async)
i_tx_byte  in  8  byte shifted out on MISO; captured at SSEL fall
o_MISO  out  1  slave-out data
o_LED  out  1  toggles on each accepted packet
o_byte_valid  out  1  1-cycle strobe per completed byte
o_byte  out  8  last completed byte
o_packet_received  out  1  1-cycle strobe per accepted packet
o_packet_data_received  out  PW  last accepted packet; first payload byte in bits [PW-1:PW-8]
o_timeout  out  1  1-cycle strobe when a packet is aborted by timeout

Behaviour:
- Reset: all outputs 0; FSM HUNT; bit count 0; timeout counter 0. Reset mid-operation discards partial byte and packet.
- Inputs pass SYNC_STAGES flops plus one edge-detect flop; internal edges are 1-cycle pulses.
- SSEL fall: bit count <- 0; i_tx_byte captured to TX shifter; o_MISO <- captured bit 7 next cycle.
- SCLK rise with SSEL low: MOSI shifted into RX shifter, MSB first; bit count +1.
- SCLK fall with SSEL low: TX shifter advances; o_MISO <- next bit. After bit 0, o_MISO holds 0.
- SSEL high: o_MISO = 0; SCLK edges ignored.
- SSEL rise before 8 bits: partial byte discarded; no strobe; FSM state kept.
- 8th rising edge: o_byte <- byte; o_byte_valid pulses the next cycle. Latency from raw SCLK rise <= SYNC_STAGES+2 cycles.
- Packet state persists across SSEL frames; one byte per frame and multi-byte frames are both legal.
- FSM HUNT: completed byte == START_BYTE -> COLLECT, index 0. Any other byte is ignored.
- FSM COLLECT: each byte is shifted into the staging register. START_BYTE inside the payload is data. On byte PKT_BYTES -> ACCEPT.
- FSM ACCEPT (1 cycle): o_packet_data_received <- staging; o_packet_received pulses; o_LED toggles; -> HUNT.
- o_packet_data_received changes only in ACCEPT.
- Timeout (TIMEOUT_CYCLES>0): the counter clears on every byte completion and counts only in COLLECT. When it reaches TIMEOUT_CYCLES: o_timeout pulses, staging is discarded, FSM -> HUNT. If a byte completes in the same cycle as the timeout, the byte wins: counter clears, no timeout.

Optional Feature:
SPI_PKT_CHECKSUM_EN
- Defined: COLLECT expects PKT_BYTES+1 bytes. The final byte must equal the XOR of all payload bytes.
  - Match: ACCEPT as normal.
  - Mismatch: o_packet_error (extra 1-bit output, reset 0) pulses 1 cycle; data and LED unchanged; -> HUNT.
- Undefined: no checksum byte and no o_packet_error port; behaviour as above.

Decomposition:
- Package spi_pkg: FSM state enum (HUNT, COLLECT, ACCEPT), BYTE_W=8, default START_BYTE, checksum XOR function.
- One sub-module, spi_byte_engine: synchronisers, edge detect, bit counter, RX/TX shifters, o_byte/o_byte_valid, o_MISO.
- The top holds the FSM, staging register, timeout counter, LED and checksum.

Test Plan:
- Send bytes FF,12,5A,11,12,F1,00,F4,F3,FF (one SSEL frame each) -> exactly one o_packet_received; data=40'h12F100F4F3; o_LED=1; 10 o_byte_valid strobes.
- Send 11 then 11,22,33,44,55 -> data=40'h1122334455; the embedded 11 is treated as data.
- Send 11,12, then 4 SCLK edges, raise SSEL, then F1,00,F4,F3 -> partial byte dropped; packet accepted = 40'h12F100F4F3.
- TIMEOUT_CYCLES=200: send 11,12, wait 300 cycles, then F1,00,F4,F3 -> o_timeout one pulse; no packet; data unchanged.
- i_tx_byte=8'hA5 with a byte sent -> MISO bits 1,0,1,0,0,1,0,1 sampled on SCLK rises; i_rst mid-byte -> all outputs 0, FSM HUNT.
- With SPI_PKT_CHECKSUM_EN: 11,12,F1,00,F4,F3,E4 -> accepted. Same sequence ending E5 -> o_packet_error pulse; LED unchanged.
